fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Fetch-stage next-PC controller. It owns the fetch PC and issues instruction-memory requests.
- It presents the fetched word (fet_instr) to the fetch predecoder and consumes the predecoder results: jal/jalr/branch/mret flags, offsets, jalr operand, jalr_dep.
- It applies static prediction (backward-taken via predict_bxxtaken), stalls on jalr register dependence, and honours execute-stage redirects.
- It hands {pc, instr, pred_taken} to decode with a valid/stall handshake.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address issued first after reset.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request, address valid this cycle
- imem_addr  out  32  fetch address, word aligned
- imem_rvalid  in  1  response valid; always exactly 1 cycle after an accepted imem_req
- imem_rdata  in  32  fetched instruction
- fet_instr  out  32  instruction presented to the predecoder (rv32_instr)
- isjal, isjalr, isbxx, ismret, predict_bxxtaken  in  1 each  predecode flags for fet_instr
- jaloffset, jalroffset, bxxoffset  in  32 each  sign-extended offsets for fet_instr
- jalr_xn  in  32  jalr base register value
- jalr_dep  in  1  jalr base register still pending in pipeline
- mepc  in  32  mret target
- exe_redirect  in  1  branch mispredict / trap redirect from execute
- exe_redirect_pc  in  32  redirect target
- dec_stall  in  1  decode cannot accept this cycle
- if_valid  out  1  fetch packet valid to decode
- if_pc  out  32  PC of if_instr
- if_instr  out  32  instruction to decode
- if_pred_taken  out  1  fetch redirected on this instruction (jal/jalr/mret/predicted-taken branch)

Behaviour:
- Reset (async, rstn=0):
  - state=BOOT, pc_q=RESET_PC, inflight=0, buf_valid=0.
  - Outputs: if_valid=0, if_pc=0, if_instr=0 (NOP not required), if_pred_taken=0, imem_req=0.
- Buffer and predecoder input:
  - fet_instr = buf_valid ? buf_q : imem_rdata.
  - The current instruction exists when (inflight & imem_rvalid) | buf_valid. Its PC is cur_pc_q.
- BOOT:
  - One cycle with imem_req=1, imem_addr=RESET_PC, cur_pc_q<=RESET_PC, inflight<=1, then go to RUN.
- RUN, when the current instruction exists and dec_stall=0:
  - Next-PC priority, highest first:
    - exe_redirect → exe_redirect_pc.
    - ismret → mepc.
    - isjal → cur_pc+jaloffset.
    - isjalr & ~jalr_dep → (jalr_xn+jalroffset) & ~1.
    - isbxx & predict_bxxtaken → cur_pc+bxxoffset.
    - else → cur_pc+4.
  - Issue imem_req=1 with imem_addr=next_pc and set cur_pc_q<=next_pc.
  - Drive if_valid=1, if_pc=cur_pc, if_instr=fet_instr, and if_pred_taken=1 when next_pc came from any rule other than +4 and redirect.
  - All arithmetic is modulo 2^32; bits [1:0] of the result are forced to 0.
- Decode stall (dec_stall=1 with a current instruction):
  - Capture imem_rdata into buf_q and set buf_valid=1 if it is not already buffered.
  - imem_req=0. All outputs hold their previous values.
- jalr with jalr_dep=1:
  - Go to JALR_WAIT. The instruction is buffered, imem_req=0, if_valid=0.
  - Re-evaluate every cycle. When jalr_dep=0, compute the target as in RUN, issue the request, emit the packet, and return to RUN.
- exe_redirect, in any state except BOOT:
  - Takes precedence over everything, including dec_stall and JALR_WAIT.
  - Clears buf_valid and discards the current instruction: if_valid=0 that cycle.
  - Issues imem_req with addr=exe_redirect_pc, sets cur_pc_q<=exe_redirect_pc, state=RUN.
- Output registers:
  - if_* are registered; decode sees the packet the cycle after the fetch response.
  - if_valid drops to 0 on any cycle where no packet is emitted and dec_stall=0.
- No more than one outstanding imem request at any time.
- If imem_rvalid arrives with inflight=0, it is ignored.

Test Plan:
- Reset then sequential: RESET_PC=0x100, four NOPs (0x00000013) → imem_addr 0x100,0x104,0x108,0x10C on consecutive cycles; if_pc follows one cycle later; if_pred_taken=0.
- jal: instr at 0x200 with jaloffset=0x40 → next imem_addr=0x240; if_pred_taken=1 for 0x200.
- Branches: backward branch (predict_bxxtaken=1, bxxoffset=0xFFFFFFF0) at 0x300 → next addr 0x2F0. Same with predict_bxxtaken=0 → 0x304.
- jalr dependence: jalr at 0x400, jalr_dep=1 for 3 cycles, then jalr_xn=0x1001, jalroffset=4 → no imem_req and if_valid=0 for 3 cycles, then imem_addr=0x1004.
- dec_stall: assert for 2 cycles mid-stream → if_* held stable, imem_req=0, no instruction lost or duplicated after release.
- Redirect and mret:
  - exe_redirect=1 with pc=0x800 during JALR_WAIT → immediate imem_addr=0x800, buffered jalr dropped.
  - mret (ismret=1, mepc=0x80) → next addr 0x80.
  - Async rstn pulse mid-stream → outputs zero immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// packet handed to decode with its stall back-pressure.
interface fetch_pc_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            dec_stall;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_pred_taken;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr, if_pred_taken,
    input  imem_rvalid, imem_rdata, dec_stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, if_pred_taken,
    output imem_rvalid, imem_rdata, dec_stall
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage next-PC controller: owns the fetch PC, applies static prediction,
// stalls on jalr operand dependence and follows execute-stage redirects.
module fetch_pc_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  fetch_pc_ctrl_if.master bus,
  output logic [XLEN-1:0] fet_instr,
  input  logic            isjal,
  input  logic            isjalr,
  input  logic            isbxx,
  input  logic            ismret,
  input  logic            predict_bxxtaken,
  input  logic [XLEN-1:0] jaloffset,
  input  logic [XLEN-1:0] jalroffset,
  input  logic [XLEN-1:0] bxxoffset,
  input  logic [XLEN-1:0] jalr_xn,
  input  logic            jalr_dep,
  input  logic [XLEN-1:0] mepc,
  input  logic            exe_redirect,
  input  logic [XLEN-1:0] exe_redirect_pc
);

  typedef enum logic [1:0] {BOOT, RUN, JALR_WAIT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] cur_pc_q, cur_pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            buf_valid_q, buf_valid_d;
  logic            inflight_q, inflight_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            if_pred_taken_q, if_pred_taken_d;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            have_instr;
  logic            jalr_blocked;
  logic            taken;
  logic [XLEN-1:0] next_pc;

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

  assign fet_instr  = buf_valid_q ? buf_q : bus.imem_rdata;
  assign have_instr = (inflight_q & bus.imem_rvalid) | buf_valid_q;
  assign jalr_blocked = isjalr & jalr_dep & ~ismret & ~isjal;

  // Static target selection for the current instruction.
  always_comb begin
    taken   = 1'b1;
    next_pc = cur_pc_q + XLEN'(4);
    if (ismret)                      next_pc = mepc;
    else if (isjal)                  next_pc = cur_pc_q + jaloffset;
    else if (isjalr)                 next_pc = (jalr_xn + jalroffset) & ~(XLEN'(1));
    else if (isbxx && predict_bxxtaken) next_pc = cur_pc_q + bxxoffset;
    else                             taken   = 1'b0;
    next_pc = align(next_pc);
  end

  always_comb begin
    state_d         = state_q;
    cur_pc_d        = cur_pc_q;
    buf_d           = buf_q;
    buf_valid_d     = buf_valid_q;
    inflight_d      = inflight_q;
    if_valid_d      = if_valid_q;
    if_pc_d         = if_pc_q;
    if_instr_d      = if_instr_q;
    if_pred_taken_d = if_pred_taken_q;
    req             = 1'b0;
    addr            = cur_pc_q;

    if (state_q == BOOT) begin
      req        = 1'b1;
      addr       = RESET_PC;
      cur_pc_d   = RESET_PC;
      inflight_d = 1'b1;
      state_d    = RUN;
    end else if (exe_redirect) begin
      // Redirect wins over stalls and jalr waits; the in-hand instruction is dropped.
      req         = 1'b1;
      addr        = align(exe_redirect_pc);
      cur_pc_d    = addr;
      inflight_d  = 1'b1;
      buf_valid_d = 1'b0;
      if_valid_d  = 1'b0;
      state_d     = RUN;
    end else if (have_instr && (bus.dec_stall || jalr_blocked)) begin
      buf_d       = fet_instr;
      buf_valid_d = 1'b1;
      inflight_d  = 1'b0;
      state_d     = jalr_blocked ? JALR_WAIT : RUN;
      if (!bus.dec_stall) if_valid_d = 1'b0;
    end else if (have_instr) begin
      req             = 1'b1;
      addr            = next_pc;
      cur_pc_d        = next_pc;
      inflight_d      = 1'b1;
      buf_valid_d     = 1'b0;
      state_d         = RUN;
      if_valid_d      = 1'b1;
      if_pc_d         = cur_pc_q;
      if_instr_d      = fet_instr;
      if_pred_taken_d = taken;
    end else if (!bus.dec_stall) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= BOOT;
      cur_pc_q        <= RESET_PC;
      buf_valid_q     <= 1'b0;
      inflight_q      <= 1'b0;
      if_valid_q      <= 1'b0;
      if_pc_q         <= '0;
      if_instr_q      <= '0;
      if_pred_taken_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_pc_q        <= cur_pc_d;
      buf_valid_q     <= buf_valid_d;
      inflight_q      <= inflight_d;
      if_valid_q      <= if_valid_d;
      if_pc_q         <= if_pc_d;
      if_instr_q      <= if_instr_d;
      if_pred_taken_q <= if_pred_taken_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // BOOT is the reset state, so the request must also be masked while reset is held.
  assign bus.imem_req      = req & rstn;
  assign bus.imem_addr     = addr;
  assign bus.if_valid      = if_valid_q;
  assign bus.if_pc         = if_pc_q;
  assign bus.if_instr      = if_instr_q;
  assign bus.if_pred_taken = if_pred_taken_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: a 1-cycle memory, a word-driven predecoder and a
// transaction-level model of the fetch packet stream and request addresses.
module tb_fetch_pc_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  // Bench predecode encoding: w[30:28] selects the kind, w[27] predicts taken,
  // w[26:8] is a sign-extended offset.
  localparam logic [31:0] JAL40  = 32'h1000_4000;
  localparam logic [31:0] JALR4  = 32'h2000_0400;
  localparam logic [31:0] BTAKEN = 32'h3FFF_F000;
  localparam logic [31:0] BNT    = 32'h37FF_F000;
  localparam logic [31:0] MRET   = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] fet_instr;
  logic        isjal, isjalr, isbxx, ismret, predict_bxxtaken;
  logic [31:0] jaloffset, jalroffset, bxxoffset, jalr_xn, mepc, exe_redirect_pc;
  logic        jalr_dep, exe_redirect;

  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.XLEN(32)) bus ();

  fetch_pc_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .bus              (bus),
    .fet_instr        (fet_instr),
    .isjal            (isjal),
    .isjalr           (isjalr),
    .isbxx            (isbxx),
    .ismret           (ismret),
    .predict_bxxtaken (predict_bxxtaken),
    .jaloffset        (jaloffset),
    .jalroffset       (jalroffset),
    .bxxoffset        (bxxoffset),
    .jalr_xn          (jalr_xn),
    .jalr_dep         (jalr_dep),
    .mepc             (mepc),
    .exe_redirect     (exe_redirect),
    .exe_redirect_pc  (exe_redirect_pc)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  bit          m_booted, m_held, m_resp_due, mem_pend, spurious_en;
  logic [31:0] m_pc, m_word;
  bit          m_if_valid, m_if_taken;
  logic [31:0] m_if_pc, m_if_instr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] offset_of(input logic [31:0] w);
    return {{13{w[26]}}, w[26:8]};
  endfunction

  task automatic predecode(input logic [31:0] w);
    isjal            = (w[30:28] == 3'd1);
    isjalr           = (w[30:28] == 3'd2);
    isbxx            = (w[30:28] == 3'd3);
    ismret           = (w[30:28] == 3'd4);
    predict_bxxtaken = w[27];
    jaloffset        = offset_of(w);
    jalroffset       = offset_of(w);
    bxxoffset        = offset_of(w);
  endtask

  // {pred_taken, next fetch address} for the instruction w fetched from pc.
  function automatic logic [32:0] target(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] t;
    bit          tk;
    tk = 1'b1;
    case (w[30:28])
      3'd4:    t = mepc;
      3'd1:    t = pc + offset_of(w);
      3'd2:    t = jalr_xn + offset_of(w);
      3'd3:    if (w[27]) t = pc + offset_of(w); else begin t = pc + 32'd4; tk = 1'b0; end
      default: begin t = pc + 32'd4; tk = 1'b0; end
    endcase
    return {tk, t & 32'hFFFF_FFFC};
  endfunction

  task automatic step(input bit redir, input logic [31:0] rpc, input bit stall,
                      input bit dep, input logic [31:0] word);
    logic [31:0] cur_w, exp_addr;
    logic [32:0] tg;
    bit          rv, have, blocked, exp_req;
    rv = mem_pend || (spurious_en && $urandom_range(7) == 0);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = word;
    bus.dec_stall   = stall;
    exe_redirect    = redir;
    exe_redirect_pc = rpc;
    jalr_dep        = dep;
    cur_w   = m_held ? m_word : word;
    predecode(cur_w);
    have    = m_booted && (m_held || (m_resp_due && rv));
    blocked = (cur_w[30:28] == 3'd2) && dep;
    @(negedge clk);
    chk("if_valid", 32'(bus.if_valid), 32'(m_if_valid));
    if (m_if_valid) begin
      chk("if_pc", bus.if_pc, m_if_pc);
      chk("if_instr", bus.if_instr, m_if_instr);
      chk("if_pred_taken", 32'(bus.if_pred_taken), 32'(m_if_taken));
    end
    if (have) chk("fet_instr", fet_instr, cur_w);
    exp_req  = 1'b0;
    exp_addr = '0;
    if (!m_booted) begin
      exp_req = 1'b1; exp_addr = RST_PC; m_pc = RST_PC; m_resp_due = 1'b1; m_booted = 1'b1;
    end else if (redir) begin
      exp_req = 1'b1; exp_addr = rpc; m_pc = rpc; m_resp_due = 1'b1; m_held = 1'b0;
      m_if_valid = 1'b0;
    end else if (have && (stall || blocked)) begin
      m_held = 1'b1; m_word = cur_w; m_resp_due = 1'b0;
      if (!stall) m_if_valid = 1'b0;
    end else if (have) begin
      tg = target(m_pc, cur_w);
      exp_req = 1'b1; exp_addr = tg[31:0];
      m_if_valid = 1'b1; m_if_pc = m_pc; m_if_instr = cur_w; m_if_taken = tg[32];
      m_pc = tg[31:0]; m_held = 1'b0; m_resp_due = 1'b1;
    end else if (!stall) begin
      m_if_valid = 1'b0;
    end
    chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, exp_addr);
    mem_pend = bus.imem_req;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_if_pred_taken", 32'(bus.if_pred_taken), 32'h0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
    m_booted = 1'b0; m_held = 1'b0; m_resp_due = 1'b0; mem_pend = 1'b0;
    m_if_valid = 1'b0; m_if_taken = 1'b0; m_if_pc = '0; m_if_instr = '0;
    bus.imem_rvalid = 1'b0;
    exe_redirect    = 1'b0;
    bus.dec_stall   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = NOP; bus.dec_stall = 1'b0;
    exe_redirect = 1'b0; exe_redirect_pc = '0; jalr_dep = 1'b0;
    jalr_xn = '0; mepc = '0; spurious_en = 1'b0;
    predecode(NOP);
    do_reset();

    // Boot plus straight-line NOPs.
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0, NOP);
    // jal +0x40 from 0x200.
    step(1'b1, 32'h200, 1'b0, 1'b0, NOP);
    step(1'b0, 32'h0, 1'b0, 1'b0, JAL40);
    step(1'b0, 32'h0, 1'b0, 1'b0, NOP);
    // Backward branch at 0x300, predicted taken then not taken.
    step(1'b1, 32'h300, 1'b0, 1'b0, NOP);
    step(1'b0, 32'h0, 1'b0, 1'b0, BTAKEN);
    step(1'b1, 32'h300, 1'b0, 1'b0, NOP);
    step(1'b0, 32'h0, 1'b0, 1'b0, BNT);
    // jalr at 0x400 waiting three cycles on its base register.
    step(1'b1, 32'h400, 1'b0, 1'b0, NOP);
    jalr_xn = 32'h1001;
    step(1'b0, 32'h0, 1'b0, 1'b1, JALR4);
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, NOP);
    step(1'b0, 32'h0, 1'b0, 1'b0, NOP);
    // Decode stall for two cycles mid-stream.
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, NOP);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, NOP);
    // Redirect while waiting on a jalr, then mret.
    step(1'b0, 32'h0, 1'b0, 1'b1, JALR4);
    step(1'b1, 32'h800, 1'b0, 1'b1, NOP);
    step(1'b0, 32'h0, 1'b0, 1'b0, NOP);
    mepc = 32'h80;
    step(1'b0, 32'h0, 1'b0, 1'b0, MRET);
    step(1'b0, 32'h0, 1'b0, 1'b0, NOP);

    // Randomized traffic with an asynchronous reset pulse midway.
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      jalr_xn = $urandom;
      mepc    = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(15) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(3) == 0, $urandom_range(1) == 1, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
